// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/sequencing control for the IF/ID/EM/WB pipeline.
// Produces ID operand forwarding selects, load-use stall/bubble, memory-wait
// freeze with timeout release, and post-redirect squash of younger fetches.
//
// Ports
//   clock, reset          clock and synchronous active-high reset
//   id_*                  ID instruction: valid, rs/rt numbers, rs/rt usage
//   em_*                  EM instruction: valid, rd, we, load, mem req/ready
//   wb_*                  WB instruction: valid, rd, we
//   redirect_in           taken branch/jump resolved in EM
//   fwd_a, fwd_b          00 regfile, 01 EM result, 10 WB result
//   pc_hold, id_hold      freeze PC / IF->ID register
//   em_hold, em_bubble    freeze EM / load NOP into EM
//   id_flush              load NOP into IF->ID register
//   mem_abort             pulse when a memory wait is forcibly released
//   mem_timeout           sticky timeout flag
//   state                 00 RUN, 01 MEM_WAIT, 10 FLUSH
//   perf_stall_cnt        pc_hold cycle counter
//
// Optional feature macro: HAZARD_PERF_EN (enables perf_stall_cnt counter;
// without it the port is tied to zero).

module pipe_hazard_ctrl #(
   parameter int unsigned MAX_WAIT    = 16,
   parameter int unsigned FLUSH_SLOTS = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        em_valid,
   input  logic [4:0]  em_rd,
   input  logic        em_we,
   input  logic        em_is_load,
   input  logic        em_mem_req,
   input  logic        em_mem_ready,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        wb_we,
   input  logic        redirect_in,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        pc_hold,
   output logic        id_hold,
   output logic        em_hold,
   output logic        em_bubble,
   output logic        id_flush,
   output logic        mem_abort,
   output logic        mem_timeout,
   output logic [1:0]  state,
   output logic [31:0] perf_stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_FLUSH    = 2'b10
   } state_t;

   localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
   localparam logic [1:0] FLUSH_LD = 2'(FLUSH_SLOTS - 1);

   state_t     r_state;
   logic [7:0] r_wait;
   logic [1:0] r_flush;
   logic       r_timeout;

   state_t     w_state_nxt;
   logic [7:0] w_wait_nxt;
   logic [1:0] w_flush_nxt;
   logic       w_take_redir;
   logic       w_em_fwd_ok;
   logic       w_wb_fwd_ok;
   logic       w_mem_stall;
   logic       w_load_use;

   // A load result is not available in EM, so EM forwarding excludes loads.
   assign w_em_fwd_ok = em_valid & em_we & (em_rd != 5'd0) & ~em_is_load;
   assign w_wb_fwd_ok = wb_valid & wb_we & (wb_rd != 5'd0);

   assign fwd_a = (w_em_fwd_ok && em_rd == id_rs) ? 2'b01 :
                  (w_wb_fwd_ok && wb_rd == id_rs) ? 2'b10 : 2'b00;
   assign fwd_b = (w_em_fwd_ok && em_rd == id_rt) ? 2'b01 :
                  (w_wb_fwd_ok && wb_rd == id_rt) ? 2'b10 : 2'b00;

   assign w_mem_stall = em_valid & em_mem_req & ~em_mem_ready;

   assign w_load_use = id_valid & em_valid & em_is_load & (em_rd != 5'd0) &
                       ((id_uses_rs & (em_rd == id_rs)) |
                        (id_uses_rt & (em_rd == id_rt)));

   always_comb begin
      w_state_nxt  = r_state;
      w_wait_nxt   = r_wait;
      w_flush_nxt  = r_flush;
      w_take_redir = 1'b0;
      pc_hold      = 1'b0;
      id_hold      = 1'b0;
      em_hold      = 1'b0;
      em_bubble    = 1'b0;
      id_flush     = 1'b0;
      mem_abort    = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (w_mem_stall) begin
               pc_hold     = 1'b1;
               id_hold     = 1'b1;
               em_hold     = 1'b1;
               w_wait_nxt  = 8'd1;
               w_state_nxt = ST_MEM_WAIT;
            end else if (redirect_in) begin
               // ID is squashed anyway, so a coincident load-use is moot.
               w_take_redir = 1'b1;
            end else if (w_load_use) begin
               pc_hold   = 1'b1;
               id_hold   = 1'b1;
               em_bubble = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (em_mem_ready) begin
               w_state_nxt  = ST_RUN;
               w_take_redir = redirect_in;
            end else if (r_wait == WAIT_MAX) begin
               mem_abort   = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               pc_hold    = 1'b1;
               id_hold    = 1'b1;
               em_hold    = 1'b1;
               w_wait_nxt = r_wait + 8'd1;
            end
         end
         ST_FLUSH: begin
            id_flush = 1'b1;
            if (redirect_in) begin
               w_take_redir = 1'b1;
            end else begin
               if (r_flush != 2'd0) begin
                  w_flush_nxt = r_flush - 2'd1;
               end
               if (r_flush <= 2'd1) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
      // The redirect cycle itself squashes one fetch; the rest come from FLUSH.
      if (w_take_redir) begin
         id_flush    = 1'b1;
         w_flush_nxt = FLUSH_LD;
         w_state_nxt = (FLUSH_LD != 2'd0) ? ST_FLUSH : ST_RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_RUN;
         r_wait    <= 8'd0;
         r_flush   <= 2'd0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_wait    <= w_wait_nxt;
         r_flush   <= w_flush_nxt;
         r_timeout <= r_timeout | mem_abort;
      end
   end

   assign state       = r_state;
   assign mem_timeout = r_timeout;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_perf <= 32'd0;
      end else if (pc_hold) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_stall_cnt = r_perf;
`else
   assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized bench for pipe_hazard_ctrl.
// A cycle-level reference model is compared against the DUT on every cycle.

module tb_pipe_hazard_ctrl;

   localparam int MAXW = 4;
   localparam int FS   = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_valid, id_uses_rs, id_uses_rt;
   logic [4:0]  id_rs, id_rt, em_rd, wb_rd;
   logic        em_valid, em_we, em_is_load, em_mem_req, em_mem_ready;
   logic        wb_valid, wb_we, redirect_in;
   logic [1:0]  fwd_a, fwd_b, state;
   logic        pc_hold, id_hold, em_hold, em_bubble, id_flush;
   logic        mem_abort, mem_timeout;
   logic [31:0] perf_stall_cnt;

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .FLUSH_SLOTS(FS)) dut (
      .clock(clock), .reset(reset),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .em_valid(em_valid), .em_rd(em_rd), .em_we(em_we),
      .em_is_load(em_is_load), .em_mem_req(em_mem_req),
      .em_mem_ready(em_mem_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
      .redirect_in(redirect_in),
      .fwd_a(fwd_a), .fwd_b(fwd_b),
      .pc_hold(pc_hold), .id_hold(id_hold), .em_hold(em_hold),
      .em_bubble(em_bubble), .id_flush(id_flush),
      .mem_abort(mem_abort), .mem_timeout(mem_timeout),
      .state(state), .perf_stall_cnt(perf_stall_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_live = 0;
   bit          m_wait, n_wait;
   int          m_done, n_done;
   int          m_owed, n_owed;
   bit          m_to, n_to;
   logic [31:0] m_stalls;
   bit          e_ph;

   function automatic logic [1:0] fwd_of(input logic [4:0] r);
      if (r == 0) return 2'd0;
      if (em_valid && em_we && !em_is_load && em_rd == r) return 2'd1;
      if (wb_valid && wb_we && wb_rd == r) return 2'd2;
      return 2'd0;
   endfunction

   always @(negedge clock) begin
      bit ih, eh, bub, fl, ab, redir_ok, lu;
      int st;
      if (m_live) begin
         e_ph = 0; ih = 0; eh = 0; bub = 0; fl = 0; ab = 0; redir_ok = 0;
         n_wait = m_wait; n_done = m_done; n_owed = m_owed; n_to = m_to;
         lu = id_valid && em_valid && em_is_load && em_rd != 0 &&
              ((id_uses_rs && em_rd == id_rs) || (id_uses_rt && em_rd == id_rt));
         if (m_wait) begin
            st = 1;
            if (em_mem_ready) begin
               n_wait = 0;
               redir_ok = 1;
            end else if (m_done + 1 == MAXW) begin
               ab = 1; n_wait = 0; n_to = 1;
            end else begin
               e_ph = 1; ih = 1; eh = 1;
               n_done = m_done + 1;
            end
         end else if (m_owed > 0) begin
            st = 2;
            fl = 1;
            n_owed = m_owed - 1;
            redir_ok = 1;
         end else begin
            st = 0;
            if (em_valid && em_mem_req && !em_mem_ready) begin
               e_ph = 1; ih = 1; eh = 1;
               n_wait = 1; n_done = 0;
            end else begin
               redir_ok = 1;
               if (lu && !redirect_in) begin
                  e_ph = 1; ih = 1; bub = 1;
               end
            end
         end
         if (redir_ok && redirect_in) begin
            fl = 1;
            n_owed = FS - 1;
         end
         chk("fwd_a", 32'(fwd_a), 32'(fwd_of(id_rs)));
         chk("fwd_b", 32'(fwd_b), 32'(fwd_of(id_rt)));
         chk("pc_hold", 32'(pc_hold), 32'(e_ph));
         chk("id_hold", 32'(id_hold), 32'(ih));
         chk("em_hold", 32'(em_hold), 32'(eh));
         chk("em_bubble", 32'(em_bubble), 32'(bub));
         chk("id_flush", 32'(id_flush), 32'(fl));
         chk("mem_abort", 32'(mem_abort), 32'(ab));
         chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
         chk("state", 32'(state), 32'(st));
`ifdef HAZARD_PERF_EN
         chk("perf", perf_stall_cnt, m_stalls);
`else
         chk("perf", perf_stall_cnt, 32'd0);
`endif
      end
   end

   always @(posedge clock) begin
      if (reset) begin
         m_live = 1; m_wait = 0; m_done = 0; m_owed = 0; m_to = 0;
         m_stalls = 32'd0;
      end else if (m_live) begin
         m_wait = n_wait; m_done = n_done; m_owed = n_owed; m_to = n_to;
         if (e_ph) m_stalls = m_stalls + 32'd1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      em_valid = 0; em_rd = 0; em_we = 0; em_is_load = 0;
      em_mem_req = 0; em_mem_ready = 0;
      wb_valid = 0; wb_rd = 0; wb_we = 0; redirect_in = 0;
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      cyc(); reset = 1; idle();
      #2;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_hold", 32'(pc_hold), 32'd0);
      cyc(); reset = 0;
   endtask

   initial begin
      reset = 1;
      idle();
      cyc(); cyc();
      #2;
      chk("rst_timeout", 32'(mem_timeout), 32'd0);
      chk("rst_perf", perf_stall_cnt, 32'd0);
      chk("rst_state0", 32'(state), 32'd0);
      reset = 0;

      // EM forwarding of r5 to both operands, r0 never forwarded
      cyc(); idle();
      id_valid = 1; id_uses_rs = 1; id_uses_rt = 1; id_rs = 5; id_rt = 5;
      em_valid = 1; em_we = 1; em_rd = 5;
      #2;
      chk("d_fa_em", 32'(fwd_a), 32'd1);
      chk("d_fb_em", 32'(fwd_b), 32'd1);
      chk("d_nohold", 32'(pc_hold), 32'd0);
      cyc(); em_rd = 0; id_rs = 0;
      #2;
      chk("d_fa_r0", 32'(fwd_a), 32'd0);

      // EM priority over WB
      cyc(); idle();
      id_valid = 1; id_rs = 7; id_uses_rs = 1;
      em_valid = 1; em_we = 1; em_rd = 7;
      wb_valid = 1; wb_we = 1; wb_rd = 7;
      #2;
      chk("d_fa_pri", 32'(fwd_a), 32'd1);
      cyc(); em_we = 0;
      #2;
      chk("d_fa_wb", 32'(fwd_a), 32'd2);

      // load-use on rt=3, then resolves through WB
      cyc(); idle();
      id_valid = 1; id_rt = 3; id_uses_rt = 1;
      em_valid = 1; em_we = 1; em_is_load = 1; em_rd = 3;
      #2;
      chk("d_lu_pc", 32'(pc_hold), 32'd1);
      chk("d_lu_id", 32'(id_hold), 32'd1);
      chk("d_lu_bub", 32'(em_bubble), 32'd1);
      cyc(); idle();
      id_valid = 1; id_rt = 3; id_uses_rt = 1;
      wb_valid = 1; wb_we = 1; wb_rd = 3;
      #2;
      chk("d_lu_fb", 32'(fwd_b), 32'd2);
      chk("d_lu_clr", 32'(pc_hold), 32'd0);

      // memory wait: ready low 3 cycles then high
      do_reset();
      idle(); em_valid = 1; em_mem_req = 1;
      #2;
      chk("d_mw_a_st", 32'(state), 32'd0);
      chk("d_mw_a_h", 32'(em_hold), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc();
         #2;
         chk("d_mw_st", 32'(state), 32'd1);
         chk("d_mw_h", 32'(em_hold), 32'd1);
      end
      cyc(); em_mem_ready = 1;
      #2;
      chk("d_mw_rdy_st", 32'(state), 32'd1);
      chk("d_mw_rdy_h", 32'(em_hold), 32'd0);
      cyc(); idle();
      #2;
      chk("d_mw_run", 32'(state), 32'd0);
`ifdef HAZARD_PERF_EN
      chk("d_mw_perf", perf_stall_cnt, 32'd3);
`else
      chk("d_mw_perf", perf_stall_cnt, 32'd0);
`endif

      // timeout: ready never comes, MAX_WAIT=4
      cyc(); idle(); em_valid = 1; em_mem_req = 1;
      for (int i = 1; i <= MAXW; i++) begin
         cyc();
         #2;
         chk("d_to_abort", 32'(mem_abort), (i == MAXW) ? 32'd1 : 32'd0);
      end
      chk("d_to_hold", 32'(em_hold), 32'd0);
      cyc(); idle();
      #2;
      chk("d_to_pulse", 32'(mem_abort), 32'd0);
      chk("d_to_flag", 32'(mem_timeout), 32'd1);
      cyc();
      #2;
      chk("d_to_sticky", 32'(mem_timeout), 32'd1);

      // redirect in RUN, FLUSH_SLOTS=2
      cyc(); redirect_in = 1;
      #2;
      chk("d_rd_fl1", 32'(id_flush), 32'd1);
      chk("d_rd_st1", 32'(state), 32'd0);
      cyc(); redirect_in = 0;
      #2;
      chk("d_rd_fl2", 32'(id_flush), 32'd1);
      chk("d_rd_st2", 32'(state), 32'd2);
      cyc();
      #2;
      chk("d_rd_fl3", 32'(id_flush), 32'd0);
      chk("d_rd_st3", 32'(state), 32'd0);

      // redirect during MEM_WAIT waits for ready
      cyc(); idle(); em_valid = 1; em_mem_req = 1;
      cyc(); redirect_in = 1;
      #2;
      chk("d_mr_ign", 32'(id_flush), 32'd0);
      chk("d_mr_st", 32'(state), 32'd1);
      cyc(); em_mem_ready = 1;
      #2;
      chk("d_mr_fl", 32'(id_flush), 32'd1);
      chk("d_mr_h", 32'(em_hold), 32'd0);
      cyc(); idle();
      #2;
      chk("d_mr_st2", 32'(state), 32'd2);
      chk("d_mr_fl2", 32'(id_flush), 32'd1);
      cyc();
      #2;
      chk("d_mr_st3", 32'(state), 32'd0);

      do_reset();
      #2;
      chk("d_rst_to", 32'(mem_timeout), 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc();
         reset        = ($urandom_range(0, 99) == 0);
         id_valid     = ($urandom_range(0, 3) != 0);
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         id_uses_rs   = $urandom_range(0, 1) == 1;
         id_uses_rt   = $urandom_range(0, 1) == 1;
         em_valid     = ($urandom_range(0, 3) != 0);
         em_rd        = 5'($urandom_range(0, 3));
         em_we        = $urandom_range(0, 1) == 1;
         em_is_load   = ($urandom_range(0, 3) == 0);
         em_mem_req   = ($urandom_range(0, 4) == 0);
         em_mem_ready = ($urandom_range(0, 9) < 3);
         wb_valid     = $urandom_range(0, 1) == 1;
         wb_rd        = 5'($urandom_range(0, 3));
         wb_we        = $urandom_range(0, 1) == 1;
         redirect_in  = ($urandom_range(0, 6) == 0);
      end
      cyc(); idle(); reset = 0;
      cyc();
      #6;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
